bus_rr_arbiter: RTL
===================

Name: bus_rr_arbiter

Overview:
Parametrised successor to the single-bus generator/arbiter. It serves `bits` independent buses, each shared by `drvrs` driver FIFOs. Per bus, it arbitrates among pending drivers, pops one packet, and pushes it to the addressed driver or, on broadcast, to every driver except the source. It adds a selectable arbitration mode, detection and dropping of illegal destinations, and per-bus drop counters.

Parameters:
bits, 1, number of independent buses (each has its own FSM and arbitration pointer)
drvrs, 4, drivers per bus (2..255)
pckg_sz, 16, packet width in bits (>= 9); destination ID = packet[pckg_sz-1 -: 8]
broadcast, 8'hFF, destination ID meaning "all drivers except source"
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
CNT_W, 16, width of the per-bus drop counter

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
pndng  in  [bits-1:0][drvrs-1:0]  driver has a packet available
D_pop  in  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head packet of each driver
pop  out  [bits-1:0][drvrs-1:0]  one-cycle pop strobe to the granted driver
push  out  [bits-1:0][drvrs-1:0]  one-cycle push strobe to destination driver(s)
D_push  out  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  packet presented to each destination
busy  out  [bits-1:0]  bus FSM not in IDLE
drop  out  [bits-1:0]  one-cycle pulse when a packet is discarded
drop_cnt  out  [bits-1:0][CNT_W-1:0]  count of discarded packets per bus

Behaviour:
- Reset (reset=1 at posedge): all FSMs go to IDLE; pop, push, drop, busy = 0; D_push = 0; drop_cnt = 0; round-robin pointer = 0. Reset overrides any state, including mid-transfer: a popped packet that has not yet been pushed is lost and is not counted.
- Per-bus FSM (the buses are fully independent): IDLE -> POP -> PUSH -> IDLE.
- IDLE: if any pndng[b] bit is set, select winner w and go to POP. Otherwise stay in IDLE.
- Round-robin mode: w is the first pending index at or after ptr, wrapping modulo drvrs.
- Fixed mode: w is the lowest pending index.
- POP (1 cycle): pop[b][w]=1; latch D_pop[b][w] into pkt and w into src; busy=1.
- PUSH (1 cycle): decode dst = pkt[pckg_sz-1 -: 8].
  - dst < drvrs and dst != src: push[b][dst]=1; D_push[b][dst]=pkt.
  - dst == broadcast: push[b][i]=1 and D_push[b][i]=pkt for every i != src.
  - Otherwise (dst >= drvrs and not broadcast, or dst == src): no push, drop[b]=1, drop_cnt[b] += 1. The counter saturates at all-ones and does not wrap.
  - In round-robin mode, ptr <= (src+1) mod drvrs. In fixed mode the pointer is unused.
- Latency: grant evaluated in cycle 0, pop in cycle 1, push in cycle 2. One packet per bus every 3 cycles at maximum throughput; back-to-back transfers have no idle gap beyond the IDLE cycle.
- Outputs are registered. D_push[b][i] holds its last value when push[b][i]=0; the value is don't-care for consumers.
- pndng is sampled only in IDLE. A driver deasserting pndng during POP or PUSH has no effect on the transfer in flight.
- If broadcast < drvrs, broadcast decoding takes precedence over unicast.

Test Plan:
- Unicast: bits=1, drvrs=4; driver 1 pending with pkt 16'h03AB. Required: pop[0][1] at cycle 1, push[0][3]=1 with D_push=16'h03AB at cycle 2, busy=1 for cycles 1-2, drop=0.
- Round-robin fairness: drivers 0, 2 and 3 continuously pending, all addressed to driver 1. Required: pop order 0, 2, 3, 0, 2, ... with one grant every 3 cycles. With ARB_MODE=1: driver 0 is granted every time.
- Broadcast: driver 2 sends 16'hFF55. Required: push[0][0], push[0][1] and push[0][3] asserted in the same cycle, each with D_push=16'hFF55; push[0][2]=0.
- Illegal destination: driver 0 sends 16'h0711 (dst 7 >= 4), then 16'h0011 (self-addressed). Required: two drop pulses, no push, drop_cnt=2. Preload the counter near saturation with CNT_W=2 and drive 5 drops: drop_cnt stays at 3.
- Reset mid-operation: assert reset during POP. Required: the next cycle has all outputs 0, FSM in IDLE, ptr=0, drop_cnt=0, and no push for the lost packet.
- Multi-bus independence: bits=2 with simultaneous traffic on both buses. Required: bus-1 grants and pushes are unaffected by bus 0 and each proceeds with identical 3-cycle timing.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//
// Purpose:
//   Serves `bits` independent buses, each shared by `drvrs` driver FIFOs.
//   Per bus, a three-state FSM (IDLE -> POP -> PUSH) picks one pending
//   driver, pops its head packet and pushes it to the addressed driver.
//   On broadcast it pushes to every driver except the source. Packets with
//   an illegal destination (out of range, or addressed to the source) are
//   dropped and counted in a saturating per-bus counter.
//   The arbitration mode is round-robin (ARB_MODE=0) or fixed priority
//   with the lowest index winning (ARB_MODE=1).
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   reset     in   synchronous, active-high
//   pndng     in   [bits][drvrs]          driver has a packet available
//   D_pop     in   [bits][drvrs][pckg_sz] head packet of each driver
//   pop       out  [bits][drvrs]          one-cycle pop strobe to the granted driver
//   push      out  [bits][drvrs]          one-cycle push strobe to destination(s)
//   D_push    out  [bits][drvrs][pckg_sz] packet presented to each destination
//   busy      out  [bits]                 bus FSM not in IDLE
//   drop      out  [bits]                 one-cycle pulse when a packet is discarded
//   drop_cnt  out  [bits][CNT_W]          saturating count of discarded packets
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         ARB_MODE  = 0,
    parameter int         CNT_W     = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [bits-1:0][drvrs-1:0]             pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]             pop,
    output logic [bits-1:0][drvrs-1:0]             push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push,
    output logic [bits-1:0]                        busy,
    output logic [bits-1:0]                        drop,
    output logic [bits-1:0][CNT_W-1:0]             drop_cnt
);

    localparam int         IDX_W   = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [8:0] DRVRS_9 = 9'(drvrs);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    for (genvar gi = 0; gi < bits; gi++) begin : g_bus
        state_t                          state_q, state_d;
        logic [IDX_W-1:0]                ptr_q, ptr_d;
        logic [IDX_W-1:0]                src_q, src_d;
        logic [pckg_sz-1:0]              pkt_q, pkt_d;
        logic [drvrs-1:0]                pop_q, pop_d;
        logic [drvrs-1:0]                push_q, push_d;
        logic [drvrs-1:0][pckg_sz-1:0]   dpush_q, dpush_d;
        logic                            busy_q, busy_d;
        logic                            drop_q, drop_d;
        logic [CNT_W-1:0]                cnt_q, cnt_d;

        logic [IDX_W-1:0]                win;
        logic                            found;
        logic [7:0]                      dst;
        logic                            is_bcast;
        logic                            is_ucast;

        // Winner search. In round-robin mode the scan starts at ptr and wraps;
        // in fixed mode it always starts at index 0.
        always_comb begin
            logic [IDX_W-1:0] cand;
            cand  = '0;
            win   = '0;
            found = 1'b0;
            for (int k = 0; k < drvrs; k++) begin
                if (ARB_MODE == 0) begin
                    cand = IDX_W'((int'(ptr_q) + k) % drvrs);
                end else begin
                    cand = IDX_W'(k);
                end
                if (!found && pndng[gi][cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end

        // Destination decode of the latched packet. Broadcast is checked
        // first so it wins even when the broadcast ID is a legal index.
        always_comb begin
            dst      = pkt_q[pckg_sz-1 -: 8];
            is_bcast = (dst == broadcast);
            is_ucast = !is_bcast && ({1'b0, dst} < DRVRS_9) && (dst != 8'(src_q));
        end

        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            src_d   = src_q;
            pkt_d   = pkt_q;
            pop_d   = '0;
            push_d  = '0;
            dpush_d = dpush_q;
            drop_d  = 1'b0;
            cnt_d   = cnt_q;

            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        // Packet and source are captured together with the
                        // grant so later pndng/D_pop changes cannot disturb
                        // the transfer in flight.
                        state_d    = S_POP;
                        src_d      = win;
                        pkt_d      = D_pop[gi][win];
                        pop_d[win] = 1'b1;
                    end
                end
                S_POP: begin
                    state_d = S_PUSH;
                    if (is_bcast) begin
                        for (int i = 0; i < drvrs; i++) begin
                            if (IDX_W'(i) != src_q) begin
                                push_d[i]  = 1'b1;
                                dpush_d[i] = pkt_q;
                            end
                        end
                    end else if (is_ucast) begin
                        for (int i = 0; i < drvrs; i++) begin
                            if (dst == 8'(i)) begin
                                push_d[i]  = 1'b1;
                                dpush_d[i] = pkt_q;
                            end
                        end
                    end else begin
                        drop_d = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (ARB_MODE == 0) begin
                        ptr_d = (src_q == IDX_W'(drvrs - 1)) ? '0 : src_q + 1'b1;
                    end
                end
                S_PUSH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            busy_d = (state_d != S_IDLE);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= S_IDLE;
                ptr_q   <= '0;
                src_q   <= '0;
                pkt_q   <= '0;
                pop_q   <= '0;
                push_q  <= '0;
                dpush_q <= '0;
                busy_q  <= 1'b0;
                drop_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                src_q   <= src_d;
                pkt_q   <= pkt_d;
                pop_q   <= pop_d;
                push_q  <= push_d;
                dpush_q <= dpush_d;
                busy_q  <= busy_d;
                drop_q  <= drop_d;
                cnt_q   <= cnt_d;
            end
        end

        assign pop[gi]      = pop_q;
        assign push[gi]     = push_q;
        assign D_push[gi]   = dpush_q;
        assign busy[gi]     = busy_q;
        assign drop[gi]     = drop_q;
        assign drop_cnt[gi] = cnt_q;
    end

endmodule
